// File: rtl/asu_ddr5_pkg.sv
// Shared write-path definitions for the DDR5 PHY: burst geometry and the
// write-CRC sequencer state encoding.
package asu_ddr5_pkg;

  localparam int cBURST_XFERS = 8;
  localparam int cBEAT_CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2
  } crc_state_e;

endpackage

// File: rtl/asu_ddr5_crc_ctrl_if.sv
// Write-data / CRC-engine / DQ-serializer signal bundle around the write-CRC sequencer.
interface asu_ddr5_crc_ctrl_if #(
  parameter int pDRAM_SIZE = 4
);

  logic                      crc_wr_en_i;
  logic                      wr_valid_i;
  logic [2*pDRAM_SIZE-1:0]   wr_data_i;
  logic                      wr_ready_o;
  logic                      crc_en_o;
  logic [2*pDRAM_SIZE-1:0]   crc_data_o;
  logic [2*pDRAM_SIZE-1:0]   crc_code_i;
  logic                      dq_valid_o;
  logic [2*pDRAM_SIZE-1:0]   dq_data_o;
  logic                      dq_crc_o;
  logic                      busy_o;
  logic                      burst_err_o;

  modport master (
    output crc_wr_en_i, wr_valid_i, wr_data_i, crc_code_i,
    input  wr_ready_o, crc_en_o, crc_data_o, dq_valid_o, dq_data_o,
           dq_crc_o, busy_o, burst_err_o
  );

  modport slave (
    input  crc_wr_en_i, wr_valid_i, wr_data_i, crc_code_i,
    output wr_ready_o, crc_en_o, crc_data_o, dq_valid_o, dq_data_o,
           dq_crc_o, busy_o, burst_err_o
  );

endinterface

// File: rtl/asu_ddr5_crc_ctrl.sv
// Write-CRC sequencer: forwards an 8-transfer burst to the DQ path and, when
// write CRC is enabled, appends the CRC engine's code as a 9th transfer.
//
// state | meaning
// IDLE  | waiting for transfer 0 of a burst
// DATA  | accepting transfers 1..7
// CRC   | one-cycle slot where the CRC transfer is issued; input stalled
module asu_ddr5_crc_ctrl
  import asu_ddr5_pkg::*;
#(
  parameter int pDRAM_SIZE = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  asu_ddr5_crc_ctrl_if.slave   bus
);

  localparam int cXFER_W = 2 * pDRAM_SIZE;
  localparam logic [cBEAT_CNT_W-1:0] cLAST_BEAT = cBEAT_CNT_W'(cBURST_XFERS - 1);

  crc_state_e              state;
  logic [cBEAT_CNT_W-1:0]  beat_cnt;
  logic                    crc_mode;
  logic                    wr_ready_q;
  logic                    dq_valid_q;
  logic                    dq_crc_q;
  logic                    crc_en_q;
  logic [cXFER_W-1:0]      dq_data_q;
  logic [cXFER_W-1:0]      crc_data_q;
  logic                    busy_q;
  logic                    burst_err_q;

  assign bus.wr_ready_o  = wr_ready_q;
  assign bus.crc_en_o    = crc_en_q;
  assign bus.crc_data_o  = crc_data_q;
  assign bus.dq_valid_o  = dq_valid_q;
  assign bus.dq_crc_o    = dq_crc_q;
  assign bus.busy_o      = busy_q;
  assign bus.burst_err_o = burst_err_q;

  // The engine's code only becomes valid in the cycle the CRC transfer is on
  // the bus, so it is passed through rather than registered to keep the
  // stream gap-free.
  assign bus.dq_data_o = dq_crc_q ? bus.crc_code_i : dq_data_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      crc_mode    <= 1'b0;
      wr_ready_q  <= 1'b1;
      dq_valid_q  <= 1'b0;
      dq_crc_q    <= 1'b0;
      crc_en_q    <= 1'b0;
      dq_data_q   <= '0;
      crc_data_q  <= '0;
      busy_q      <= 1'b0;
      burst_err_q <= 1'b0;
    end else begin
      dq_crc_q <= 1'b0;
      case (state)
        IDLE: begin
          dq_valid_q <= bus.wr_valid_i;
          crc_en_q   <= 1'b0;
          if (bus.wr_valid_i) begin
            dq_data_q  <= bus.wr_data_i;
            crc_data_q <= bus.wr_data_i;
            crc_mode   <= bus.crc_wr_en_i;
            crc_en_q   <= bus.crc_wr_en_i;
            beat_cnt   <= cBEAT_CNT_W'(1);
            busy_q     <= 1'b1;
            state      <= DATA;
          end
        end
        DATA: begin
          if (bus.wr_valid_i) begin
            dq_valid_q <= 1'b1;
            dq_data_q  <= bus.wr_data_i;
            crc_data_q <= bus.wr_data_i;
            crc_en_q   <= crc_mode;
            beat_cnt   <= beat_cnt + 1'b1;
            if (beat_cnt == cLAST_BEAT) begin
              if (crc_mode) begin
                wr_ready_q <= 1'b0;
                state      <= CRC;
              end else begin
                busy_q <= 1'b0;
                state  <= IDLE;
              end
            end
          end else begin
            // Stream broken mid-burst: abandon it without a CRC transfer.
            burst_err_q <= 1'b1;
            dq_valid_q  <= 1'b0;
            crc_en_q    <= 1'b0;
            beat_cnt    <= '0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        CRC: begin
          dq_valid_q <= 1'b1;
          dq_crc_q   <= 1'b1;
          crc_en_q   <= 1'b0;
          wr_ready_q <= 1'b1;
          beat_cnt   <= '0;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          dq_valid_q <= 1'b0;
          crc_en_q   <= 1'b0;
          wr_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_asu_ddr5_crc_ctrl.sv
// Directed bench for the write-CRC sequencer with a toy rotate-xor CRC engine.
module tb_asu_ddr5_crc_ctrl;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  asu_ddr5_crc_ctrl_if #(.pDRAM_SIZE(4)) bus ();

  asu_ddr5_crc_ctrl #(.pDRAM_SIZE(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  // Toy engine: acc = rotl(acc) ^ data per enabled cycle, restarting at 0 on
  // the first enabled cycle of a run. Code valid the cycle after the last enable.
  logic [7:0] eng_acc, eng_base;
  logic       eng_prev;
  always_comb eng_base = eng_prev ? eng_acc : 8'h00;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      eng_acc  <= 8'h00;
      eng_prev <= 1'b0;
    end else begin
      eng_prev <= bus.crc_en_o;
      if (bus.crc_en_o) eng_acc <= {eng_base[6:0], eng_base[7]} ^ bus.crc_data_o;
    end
  end
  assign bus.crc_code_i = eng_acc;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc_n, n_valid, n_en, n_crcx, n_rdy_low, first_v, last_v, crc_pos;
  logic [7:0] dq_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    n_valid = 0; n_en = 0; n_crcx = 0; n_rdy_low = 0;
    first_v = 0; last_v = 0; crc_pos = -1;
    dq_q.delete();
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
    cyc_n++;
    if (bus.dq_valid_o) begin
      if (n_valid == 0) first_v = cyc_n;
      last_v = cyc_n;
      n_valid++;
      if (bus.dq_crc_o) crc_pos = dq_q.size();
      dq_q.push_back(bus.dq_data_o);
    end
    if (bus.crc_en_o) n_en++;
    if (bus.dq_crc_o) n_crcx++;
    if (!bus.wr_ready_o) n_rdy_low++;
  endtask

  // Sends n transfers base, base+1, ...; crc_wr_en_i switches to 0 from
  // transfer index off_at onward.
  task automatic send(input int n, input logic [7:0] base, input logic mode, input int off_at);
    int i, guard;
    logic acc;
    i = 0; guard = 0;
    while (i < n) begin
      bus.wr_valid_i  = 1'b1;
      bus.wr_data_i   = base + 8'(i);
      bus.crc_wr_en_i = (i >= off_at) ? 1'b0 : mode;
      acc = bus.wr_ready_o;
      cyc();
      if (acc) i++;
      guard++;
      if (guard > 50) begin
        chk("send_timeout", 32'(guard), 32'd0);
        break;
      end
    end
    bus.wr_valid_i = 1'b0;
  endtask

  task automatic drain(input int k);
    repeat (k) cyc();
  endtask

  initial begin
    cyc_n = 0;
    bus.wr_valid_i  = 1'b0;
    bus.wr_data_i   = 8'h00;
    bus.crc_wr_en_i = 1'b0;
    clr_mon();

    // Reset state
    #12;
    chk("rst_dq_valid", 32'(bus.dq_valid_o), 32'd0);
    chk("rst_dq_data",  32'(bus.dq_data_o),  32'd0);
    chk("rst_busy",     32'(bus.busy_o),     32'd0);
    chk("rst_err",      32'(bus.burst_err_o),32'd0);
    @(negedge clk_i) rst_i = 1'b1;
    cyc();
    chk("rst_ready", 32'(bus.wr_ready_o), 32'd1);

    // CRC-enabled burst 01..08
    clr_mon();
    send(8, 8'h01, 1'b1, 99);
    drain(3);
    chk("t1_nvalid", 32'(n_valid), 32'd9);
    chk("t1_contig", 32'(last_v - first_v + 1), 32'd9);
    for (int k = 0; k < 8; k++) chk("t1_data", 32'(dq_q[k]), 32'(k + 1));
    chk("t1_crc_code", 32'(dq_q[8]), 32'h16);
    chk("t1_crc_pos",  32'(crc_pos), 32'd8);
    chk("t1_ncrcx",    32'(n_crcx), 32'd1);
    chk("t1_nen",      32'(n_en), 32'd8);
    chk("t1_rdy_low",  32'(n_rdy_low), 32'd1);

    // CRC-disabled burst
    clr_mon();
    send(8, 8'h01, 1'b0, 99);
    drain(3);
    chk("t2_nvalid",  32'(n_valid), 32'd8);
    chk("t2_contig",  32'(last_v - first_v + 1), 32'd8);
    chk("t2_last",    32'(dq_q[7]), 32'h08);
    chk("t2_nen",     32'(n_en), 32'd0);
    chk("t2_ncrcx",   32'(n_crcx), 32'd0);
    chk("t2_rdy_low", 32'(n_rdy_low), 32'd0);

    // Back-to-back CRC bursts 01..10
    clr_mon();
    send(16, 8'h01, 1'b1, 99);
    drain(3);
    chk("t3_nvalid",  32'(n_valid), 32'd18);
    chk("t3_contig",  32'(last_v - first_v + 1), 32'd18);
    chk("t3_crc1",    32'(dq_q[8]), 32'h16);
    chk("t3_b2_x0",   32'(dq_q[9]), 32'h09);
    chk("t3_crc2",    32'(dq_q[17]), 32'hF9);
    chk("t3_ncrcx",   32'(n_crcx), 32'd2);
    chk("t3_rdy_low", 32'(n_rdy_low), 32'd2);

    // Stream broken after transfer 4
    clr_mon();
    send(5, 8'h21, 1'b1, 99);
    chk("t4_busy_mid", 32'(bus.busy_o), 32'd1);
    chk("t4_err_pre",  32'(bus.burst_err_o), 32'd0);
    drain(3);
    chk("t4_err",      32'(bus.burst_err_o), 32'd1);
    chk("t4_busy",     32'(bus.busy_o), 32'd0);
    chk("t4_nvalid",   32'(n_valid), 32'd5);
    chk("t4_ncrcx",    32'(n_crcx), 32'd0);
    clr_mon();
    send(8, 8'h01, 1'b1, 99);
    drain(3);
    chk("t4_next_nvalid", 32'(n_valid), 32'd9);
    chk("t4_next_crc",    32'(dq_q[8]), 32'h16);
    chk("t4_err_sticky",  32'(bus.burst_err_o), 32'd1);

    // crc_wr_en_i dropped at transfer 3 is ignored until the next burst
    clr_mon();
    send(8, 8'h41, 1'b1, 3);
    drain(3);
    chk("t5_nvalid", 32'(n_valid), 32'd9);
    chk("t5_ncrcx",  32'(n_crcx), 32'd1);
    chk("t5_nen",    32'(n_en), 32'd8);
    clr_mon();
    send(8, 8'h51, 1'b0, 99);
    drain(3);
    chk("t5b_nvalid", 32'(n_valid), 32'd8);
    chk("t5b_ncrcx",  32'(n_crcx), 32'd0);

    // Reset mid-DATA after transfer 5
    clr_mon();
    send(6, 8'h61, 1'b1, 99);
    chk("t6_busy_pre", 32'(bus.busy_o), 32'd1);
    rst_i = 1'b0;
    #1;
    chk("t6_dq_valid", 32'(bus.dq_valid_o), 32'd0);
    chk("t6_dq_crc",   32'(bus.dq_crc_o), 32'd0);
    chk("t6_crc_en",   32'(bus.crc_en_o), 32'd0);
    chk("t6_dq_data",  32'(bus.dq_data_o), 32'd0);
    chk("t6_crc_data", 32'(bus.crc_data_o), 32'd0);
    chk("t6_busy",     32'(bus.busy_o), 32'd0);
    chk("t6_err",      32'(bus.burst_err_o), 32'd0);
    @(negedge clk_i) rst_i = 1'b1;
    cyc();
    chk("t6_ready", 32'(bus.wr_ready_o), 32'd1);
    clr_mon();
    send(8, 8'h01, 1'b1, 99);
    drain(3);
    chk("t6_nvalid", 32'(n_valid), 32'd9);
    chk("t6_first",  32'(dq_q[0]), 32'h01);
    chk("t6_crc",    32'(dq_q[8]), 32'h16);
    chk("t6_err_after", 32'(bus.burst_err_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
